// File: rtl/yutorina_bus_pkg.sv
// Shared bus constants: owner encoding, hold counter width and the active-low
// grant levels used by the bus arbiter and its picker.
package yutorina_bus_pkg;

    localparam int BUS_OWNER_W     = 2;
    localparam int BUS_HOLD_CNT_W  = 8;
    localparam int BUS_NUM_MASTERS = 4;

    typedef logic [BUS_OWNER_W-1:0]    bus_owner_t;
    typedef logic [BUS_HOLD_CNT_W-1:0] bus_hold_cnt_t;

    localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // One-hot-low grant pattern for a given owner index.
    function automatic logic [BUS_NUM_MASTERS-1:0] grant_decode(input bus_owner_t o);
        logic [BUS_NUM_MASTERS-1:0] g;
        g    = {BUS_NUM_MASTERS{DISABLE_}};
        g[o] = ENABLE_;
        return g;
    endfunction

endpackage

// File: rtl/yutorina_bus_rr_pick.sv
// Combinational round-robin picker: first active request after the current
// owner, scanning owner+1, owner+2, owner+3 (mod 4). The owner itself is never picked.
module yutorina_bus_rr_pick
    import yutorina_bus_pkg::*;
(
    input  logic [1:0] owner,
    input  logic [3:0] req,
    output logic [1:0] next_owner,
    output logic       found
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        cand       = owner;
        for (int i = BUS_NUM_MASTERS - 1; i >= 1; i--) begin
            cand = owner + BUS_OWNER_W'(i);
            if (req[cand]) begin
                next_owner = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests/grants and an
// optional hold limit that forces rotation while others are waiting.
module yutorina_bus_arbiter
    import yutorina_bus_pkg::*;
#(
    parameter int HOLD_MAX   = 0,
    parameter int HOLD_CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(HOLD_MAX);
    localparam bit HOLD_EN = (HOLD_MAX != 0);

    bus_owner_t              owner_q;
    bus_owner_t              next_owner;
    bus_owner_t              pick_owner;
    logic                    pick_found;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [HOLD_CNT_W-1:0]   next_hold_cnt;
    logic [3:0]              req;
    logic [3:0]              grnt_q;
    logic                    owner_req;

    assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req[owner_q];

    yutorina_bus_rr_pick u_pick (
        .owner      (owner_q),
        .req        (req),
        .next_owner (pick_owner),
        .found      (pick_found)
    );

    // Release hands off to the next requester; a saturated hold does the same
    // only when someone else is actually waiting.
    always_comb begin
        next_owner    = owner_q;
        next_hold_cnt = hold_cnt;
        if (!owner_req) begin
            if (pick_found) next_owner = pick_owner;
        end else if (HOLD_EN && (hold_cnt == HOLD_LIMIT) && pick_found) begin
            next_owner = pick_owner;
        end

        if (next_owner != owner_q)
            next_hold_cnt = '0;
        else if (!owner_req)
            next_hold_cnt = '0;
        else if (hold_cnt != HOLD_LIMIT)
            next_hold_cnt = hold_cnt + HOLD_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= BUS_OWNER_MASTER_0;
            hold_cnt <= '0;
            grnt_q   <= grant_decode(BUS_OWNER_MASTER_0);
        end else begin
            owner_q  <= next_owner;
            hold_cnt <= next_hold_cnt;
            grnt_q   <= grant_decode(next_owner);
        end
    end

    assign owner    = owner_q;
    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for the bus arbiter: one instance without a hold limit and
// one with HOLD_MAX=4, driven by the same requests.
module tb_yutorina_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;

    logic       a_g0, a_g1, a_g2, a_g3;
    logic [1:0] a_owner;
    logic       b_g0, b_g1, b_g2, b_g3;
    logic [1:0] b_owner;

    int checks   = 0;
    int failures = 0;

    yutorina_bus_arbiter #(.HOLD_MAX(0), .HOLD_CNT_W(8)) dut_h0 (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (a_g0),
        .m1_grnt_ (a_g1),
        .m2_grnt_ (a_g2),
        .m3_grnt_ (a_g3),
        .owner    (a_owner)
    );

    yutorina_bus_arbiter #(.HOLD_MAX(4), .HOLD_CNT_W(8)) dut_h4 (
        .clk      (clk),
        .reset    (reset),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (b_g0),
        .m1_grnt_ (b_g1),
        .m2_grnt_ (b_g2),
        .m3_grnt_ (b_g3),
        .owner    (b_owner)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Owner index plus the full one-hot-low grant vector for one or both instances.
    task automatic expect_owner(input string tag, input int exp_a, input int exp_b,
                                input bit do_a, input bit do_b);
        logic [3:0] ga, gb;
        ga = 4'b1111;
        gb = 4'b1111;
        ga[exp_a[1:0]] = 1'b0;
        gb[exp_b[1:0]] = 1'b0;
        if (do_a) begin
            check({tag, "_h0_owner"}, 32'(a_owner), 32'(exp_a));
            check({tag, "_h0_grnt"}, 32'({a_g3, a_g2, a_g1, a_g0}), 32'(ga));
        end
        if (do_b) begin
            check({tag, "_h4_owner"}, 32'(b_owner), 32'(exp_b));
            check({tag, "_h4_grnt"}, 32'({b_g3, b_g2, b_g1, b_g0}), 32'(gb));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        m0_req_ = 1'b1;
        m1_req_ = 1'b1;
        m2_req_ = 1'b1;
        m3_req_ = 1'b1;
        tick(2);
        expect_owner("in_reset", 0, 0, 1, 1);
        reset = 1'b0;

        // idle bus parks on master 0
        for (int i = 0; i < 10; i++) begin
            tick(1);
            expect_owner("idle", 0, 0, 1, 1);
        end

        // m2 requests from an idle bus
        m2_req_ = 1'b0;
        expect_owner("m2_req_pre", 0, 0, 1, 1);
        tick(1);
        expect_owner("m2_grant", 2, 2, 1, 1);
        tick(2);
        expect_owner("m2_hold", 2, 2, 1, 1);
        m2_req_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_owner("m2_park", 2, 2, 1, 1);
        end

        // m1 takes over, then releases with three others requesting
        m1_req_ = 1'b0;
        tick(1);
        expect_owner("m1_grant", 1, 1, 1, 1);
        tick(1);
        expect_owner("m1_hold", 1, 1, 1, 1);
        m1_req_ = 1'b1;
        m0_req_ = 1'b0;
        m2_req_ = 1'b0;
        m3_req_ = 1'b0;
        tick(1);
        expect_owner("rr_to_2", 2, 2, 1, 1);
        m2_req_ = 1'b1;
        tick(1);
        expect_owner("rr_to_3", 3, 3, 1, 1);
        m3_req_ = 1'b1;
        tick(1);
        expect_owner("rr_wrap_0", 0, 0, 1, 1);
        m0_req_ = 1'b1;
        tick(1);
        expect_owner("park_0", 0, 0, 1, 1);

        // m1 holds with m3 waiting: forced rotation only with a hold limit
        m1_req_ = 1'b0;
        m3_req_ = 1'b0;
        tick(1);
        expect_owner("hold_own", 1, 1, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            expect_owner("hold_cnt", 1, 1, 1, 1);
        end
        tick(1);
        expect_owner("hold_rotate", 1, 3, 1, 1);
        tick(1);
        expect_owner("hold_m3", 1, 3, 1, 1);
        m3_req_ = 1'b1;
        tick(1);
        expect_owner("hold_back_m1", 1, 1, 1, 1);
        m1_req_ = 1'b1;
        tick(1);
        expect_owner("hold_park", 1, 1, 1, 1);

        // no hold limit: m0 keeps the bus for 300 cycles despite m1 waiting
        m0_req_ = 1'b0;
        tick(1);
        expect_owner("long_own", 0, 0, 1, 1);
        m1_req_ = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            if (i % 25 == 0) expect_owner("long_hold", 0, 0, 1, 0);
        end
        m0_req_ = 1'b1;
        m1_req_ = 1'b1;
        m3_req_ = 1'b0;
        tick(1);
        expect_owner("m3_own", 3, 3, 1, 1);

        // asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        expect_owner("async_reset", 0, 0, 1, 1);
        #2;
        reset = 1'b0;
        tick(1);
        expect_owner("post_reset", 3, 3, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
